// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the decode stage's fetch, regFile, writeback, hazard and ID/EX signals.
//   master: drives the stage's inputs (fetch, regFile data, writeback, EX hazard info, flush, outReady)
//   slave : the decode stage itself (inReady, readAddress*, ID/EX bundle)
interface decode_stage_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
    logic              inValid;
    logic              inReady;
    logic [31:0]       inInstr;
    logic [DATA_W-1:0] inPc;
    logic [ADDR_W-1:0] readAddress0;
    logic [ADDR_W-1:0] readAddress1;
    logic [DATA_W-1:0] readData0;
    logic [DATA_W-1:0] readData1;
    logic              wbWriteEnable;
    logic [ADDR_W-1:0] wbWriteAddress;
    logic [DATA_W-1:0] wbWriteData;
    logic              exValid;
    logic              exMemRead;
    logic [ADDR_W-1:0] exDest;
    logic              flush;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outPc;
    logic [DATA_W-1:0] outRsData;
    logic [DATA_W-1:0] outRtData;
    logic [DATA_W-1:0] outImm;
    logic [ADDR_W-1:0] outDest;
    logic [5:0]        outFunct;
    logic              outRegWrite;
    logic              outMemRead;
    logic              outMemWrite;
    logic              outBranch;
    logic              outJump;
    logic              outIllegal;

    modport master (
        output inValid, inInstr, inPc, readData0, readData1, wbWriteEnable, wbWriteAddress,
               wbWriteData, exValid, exMemRead, exDest, flush, outReady,
        input  inReady, readAddress0, readAddress1, outValid, outPc, outRsData, outRtData,
               outImm, outDest, outFunct, outRegWrite, outMemRead, outMemWrite, outBranch,
               outJump, outIllegal
    );

    modport slave (
        input  inValid, inInstr, inPc, readData0, readData1, wbWriteEnable, wbWriteAddress,
               wbWriteData, exValid, exMemRead, exDest, flush, outReady,
        output inReady, readAddress0, readAddress1, outValid, outPc, outRsData, outRtData,
               outImm, outDest, outFunct, outRegWrite, outMemRead, outMemWrite, outBranch,
               outJump, outIllegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: instruction decode stage feeding a registered ID/EX bundle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_stage_if.slave -- fetch handshake, regFile read ports, writeback
//                bypass, EX load-use info, flush and the ID/EX valid/ready bundle
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, nextState;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs, rt, rd, dest;
    logic              isR, isLw, isSw, isBeq, isAddi, isJ, legal, usesRt;
    logic              stall, accept, transfer;
    logic [DATA_W-1:0] rsVal, rtVal;

    assign opcode = bus.inInstr[31:26];
    assign rs     = bus.inInstr[25:21];
    assign rt     = bus.inInstr[20:16];
    assign rd     = bus.inInstr[15:11];

    assign isR    = opcode == OP_R;
    assign isLw   = opcode == OP_LW;
    assign isSw   = opcode == OP_SW;
    assign isBeq  = opcode == OP_BEQ;
    assign isAddi = opcode == OP_ADDI;
    assign isJ    = opcode == OP_J;
    assign legal  = isR || isLw || isSw || isBeq || isAddi || isJ;
    assign usesRt = isR || isSw || isBeq;
    assign dest   = isR ? rd : (isLw || isAddi) ? rt : '0;

    assign bus.readAddress0 = rs;
    assign bus.readAddress1 = rt;

    // A load in EX cannot forward in time; hold the consumer back one cycle.
    assign stall = bus.inValid && bus.exValid && bus.exMemRead && bus.exDest != '0 &&
                   (bus.exDest == rs || (usesRt && bus.exDest == rt));

    assign bus.inReady = !bus.flush && !stall && (!bus.outValid || bus.outReady);
    assign accept      = bus.inValid && bus.inReady;
    assign transfer    = bus.outValid && bus.outReady;
    assign bus.outValid = state == FULL;

    // The regFile commits the writeback at the same edge, so its read data is stale
    // when the write index matches; $0 always reads as zero.
    always_comb begin
        rsVal = rs == '0 ? '0 : (bus.wbWriteEnable && bus.wbWriteAddress == rs) ? bus.wbWriteData : bus.readData0;
        rtVal = rt == '0 ? '0 : (bus.wbWriteEnable && bus.wbWriteAddress == rt) ? bus.wbWriteData : bus.readData1;
    end

    always_comb begin
        nextState = state;
        nextState = bus.flush ? EMPTY : accept ? FULL : transfer ? EMPTY : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outPc       <= '0;
            bus.outRsData   <= '0;
            bus.outRtData   <= '0;
            bus.outImm      <= '0;
            bus.outDest     <= '0;
            bus.outFunct    <= '0;
            bus.outRegWrite <= 1'b0;
            bus.outMemRead  <= 1'b0;
            bus.outMemWrite <= 1'b0;
            bus.outBranch   <= 1'b0;
            bus.outJump     <= 1'b0;
            bus.outIllegal  <= 1'b0;
        end else if (accept) begin
            bus.outPc       <= bus.inPc;
            bus.outRsData   <= rsVal;
            bus.outRtData   <= rtVal;
            bus.outImm      <= DATA_W'({{16{bus.inInstr[15]}}, bus.inInstr[15:0]});
            bus.outDest     <= dest;
            bus.outFunct    <= bus.inInstr[5:0];
            bus.outRegWrite <= isR || isLw || isAddi;
            bus.outMemRead  <= isLw;
            bus.outMemWrite <= isSw;
            bus.outBranch   <= isBeq;
            bus.outJump     <= isJ;
            bus.outIllegal  <= !legal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a behavioural model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nCmp = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    decode_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  dest;
        logic [5:0]  funct;
        logic        rw, mr, mw, br, jp, ill;
    } bundle_t;

    bundle_t expB = '0;
    bit      expValid = 1'b0;
    bit      everAccepted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (bus.wbWriteEnable && bus.wbWriteAddress == idx) return bus.wbWriteData;
        return rf;
    endfunction

    function automatic bundle_t predict();
        bundle_t b = '0;
        logic [4:0] rs = bus.inInstr[25:21];
        logic [4:0] rt = bus.inInstr[20:16];
        b.pc    = bus.inPc;
        b.rs    = operand(rs, bus.readData0);
        b.rt    = operand(rt, bus.readData1);
        b.imm   = 32'($signed(bus.inInstr[15:0]));
        b.funct = bus.inInstr[5:0];
        case (bus.inInstr[31:26])
            6'h00: begin b.dest = bus.inInstr[15:11]; b.rw = 1; end
            6'h23: begin b.dest = rt; b.rw = 1; b.mr = 1; end
            6'h2b: b.mw = 1;
            6'h04: b.br = 1;
            6'h08: begin b.dest = rt; b.rw = 1; end
            6'h02: b.jp = 1;
            default: b.ill = 1;
        endcase
        return b;
    endfunction

    function automatic bit modelStall();
        logic [5:0] op = bus.inInstr[31:26];
        bit usesRt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
        return bus.inValid && bus.exValid && bus.exMemRead && bus.exDest != 0 &&
               (bus.exDest == bus.inInstr[25:21] || (usesRt && bus.exDest == bus.inInstr[20:16]));
    endfunction

    task automatic checkBundle(input string tag);
        chk({tag, ".pc"},    bus.outPc,             expB.pc);
        chk({tag, ".rs"},    bus.outRsData,         expB.rs);
        chk({tag, ".rt"},    bus.outRtData,         expB.rt);
        chk({tag, ".imm"},   bus.outImm,            expB.imm);
        chk({tag, ".dest"},  32'(bus.outDest),      32'(expB.dest));
        chk({tag, ".funct"}, 32'(bus.outFunct),     32'(expB.funct));
        chk({tag, ".ctl"},   32'({bus.outRegWrite, bus.outMemRead, bus.outMemWrite, bus.outBranch, bus.outJump, bus.outIllegal}),
                             32'({expB.rw, expB.mr, expB.mw, expB.br, expB.jp, expB.ill}));
    endtask

    // One clock: check combinational outputs before the edge, then the registered bundle after it.
    task automatic step(input string tag);
        bundle_t p;
        bit expReady;
        #1;
        p = predict();
        expReady = !bus.flush && !modelStall() && (!expValid || bus.outReady);
        chk({tag, ".inReady"}, 32'(bus.inReady), 32'(expReady));
        chk({tag, ".ra0"}, 32'(bus.readAddress0), 32'(bus.inInstr[25:21]));
        chk({tag, ".ra1"}, 32'(bus.readAddress1), 32'(bus.inInstr[20:16]));
        @(posedge clk);
        #1;
        if (bus.flush) expValid = 0;
        else if (bus.inValid && expReady) begin expValid = 1; expB = p; everAccepted = 1; end
        else if (expValid && bus.outReady) expValid = 0;
        chk({tag, ".outValid"}, 32'(bus.outValid), 32'(expValid));
        if (expValid || !everAccepted) checkBundle(tag);
    endtask

    initial begin
        bus.inValid = 0; bus.inInstr = 0; bus.inPc = 0;
        bus.readData0 = 0; bus.readData1 = 0;
        bus.wbWriteEnable = 0; bus.wbWriteAddress = 0; bus.wbWriteData = 0;
        bus.exValid = 0; bus.exMemRead = 0; bus.exDest = 0;
        bus.flush = 0; bus.outReady = 1;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset.outValid", 32'(bus.outValid), 32'h0);
        checkBundle("reset");
        rst_n = 1;

        // addi $9,$8,5
        bus.inValid = 1; bus.inInstr = 32'h21090005; bus.inPc = 32'h40;
        bus.readData0 = 32'h1; bus.readData1 = 32'hdead;
        step("addi");
        chk("addi.rsConst", bus.outRsData, 32'h1);
        chk("addi.immConst", bus.outImm, 32'h5);
        chk("addi.destConst", 32'(bus.outDest), 32'd9);
        chk("addi.rwConst", 32'(bus.outRegWrite), 32'h1);

        // add $10,$8,$9 with writeback bypass on rt
        bus.inInstr = 32'h01095020; bus.inPc = 32'h44;
        bus.readData0 = 32'h3; bus.readData1 = 32'h1;
        bus.wbWriteEnable = 1; bus.wbWriteAddress = 9; bus.wbWriteData = 32'h77;
        step("bypass");
        chk("bypass.rtConst", bus.outRtData, 32'h77);

        // add $10,$0,$9: $0 reads zero even with a bypass to $0
        bus.inInstr = 32'h00095020; bus.inPc = 32'h48;
        bus.readData0 = 32'h55; bus.wbWriteAddress = 0;
        step("zeroReg");
        chk("zeroReg.rsConst", bus.outRsData, 32'h0);

        // Load-use stall on rs
        bus.wbWriteEnable = 0;
        bus.inInstr = 32'h01095020; bus.inPc = 32'h4c;
        bus.exValid = 1; bus.exMemRead = 1; bus.exDest = 8;
        step("stall");
        chk("stall.bubble", 32'(bus.outValid), 32'h0);
        bus.exValid = 0;
        step("unstall");
        chk("unstall.pc", bus.outPc, 32'h4c);

        // Back-pressure: bundle holds while outReady is low
        bus.outReady = 0; bus.inInstr = 32'h8d0a0010; bus.inPc = 32'h50;
        step("hold0"); step("hold1"); step("hold2");
        chk("hold.pc", bus.outPc, 32'h4c);
        bus.outReady = 1;
        step("release");
        chk("release.pc", bus.outPc, 32'h50);

        // Flush with a valid instruction
        bus.flush = 1; bus.inInstr = 32'hac0a0004; bus.inPc = 32'h54;
        step("flush");
        chk("flush.outValid", 32'(bus.outValid), 32'h0);
        bus.flush = 0;

        // Illegal opcode
        bus.inInstr = 32'hfc001234; bus.inPc = 32'h58;
        step("illegal");
        chk("illegal.ill", 32'(bus.outIllegal), 32'h1);

        // Asynchronous reset while the bundle is valid
        #2 rst_n = 0;
        #1;
        chk("asyncRst.outValid", 32'(bus.outValid), 32'h0);
        chk("asyncRst.pc", bus.outPc, 32'h0);
        chk("asyncRst.ill", 32'(bus.outIllegal), 32'h0);
        expValid = 0; expB = '0; everAccepted = 0;
        #1 rst_n = 1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 6))
                0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2b; 3: op = 6'h04;
                4: op = 6'h08; 5: op = 6'h02; default: op = 6'($urandom);
            endcase
            bus.inValid = $urandom_range(0, 3) != 0;
            bus.inInstr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            bus.inPc = $urandom;
            bus.readData0 = $urandom; bus.readData1 = $urandom;
            bus.wbWriteEnable = $urandom_range(0, 1) == 1;
            bus.wbWriteAddress = 5'($urandom_range(0, 7));
            bus.wbWriteData = $urandom;
            bus.exValid = $urandom_range(0, 1) == 1;
            bus.exMemRead = $urandom_range(0, 1) == 1;
            bus.exDest = 5'($urandom_range(0, 7));
            bus.flush = $urandom_range(0, 9) == 0;
            bus.outReady = $urandom_range(0, 2) != 0;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage that sits directly upstream of the 32x32 register file (regFile).
- Drives the file's two read addresses from the incoming instruction and captures the returned read data.
- Bypasses the same-cycle writeback value, detects load-use hazards, and produces a registered ID/EX bundle under a valid/ready handshake.
- Supported subset: R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000), j (000010).

Parameters:
- DATA_W, 32, datapath/register width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- inValid  in  1  fetch presents an instruction
- inReady  out  1  stage accepts the instruction this cycle
- inInstr  in  32  instruction word
- inPc  in  32  PC of inInstr
- readAddress0  out  5  to regFile, equals inInstr[25:21] (rs); combinational
- readAddress1  out  5  to regFile, equals inInstr[20:16] (rt); combinational
- readData0  in  32  from regFile
- readData1  in  32  from regFile
- wbWriteEnable  in  1  regFile write strobe this cycle
- wbWriteAddress  in  5  regFile write index
- wbWriteData  in  32  regFile write data
- exValid  in  1  EX stage holds a valid instruction
- exMemRead  in  1  EX instruction is a load
- exDest  in  5  EX destination register
- flush  in  1  branch/jump redirect; kill the stage
- outValid  out  1  ID/EX bundle valid
- outReady  in  1  EX accepts the bundle
- outPc  out  32  registered PC
- outRsData  out  32  operand A
- outRtData  out  32  operand B
- outImm  out  32  sign-extended inInstr[15:0]
- outDest  out  5  rd for R-type, rt for lw/addi, 0 otherwise
- outFunct  out  6  inInstr[5:0]
- outRegWrite  out  1  instruction writes the register file
- outMemRead  out  1  lw
- outMemWrite  out  1  sw
- outBranch  out  1  beq
- outJump  out  1  j
- outIllegal  out  1  opcode outside the subset

Behaviour:
- Reset (rst_n low, asynchronous): all out* registers go to 0, including outValid=0. readAddress* remain combinational from inInstr.
- Output register has two states:
  - EMPTY: outValid=0.
  - FULL: outValid=1.
- Transfer: a transfer occurs when outValid && outReady.
- Load-use stall:
  - stall = inValid && exValid && exMemRead && exDest!=0 && (exDest==rs || (usesRt && exDest==rt)).
  - usesRt is 1 for R-type, sw, beq; 0 otherwise.
- inReady = !flush && !stall && (!outValid || outReady).
- Accept (inValid && inReady): the bundle is registered at the next edge and outValid becomes 1. Latency is 1 cycle from accept to outValid.
- No accept and a transfer occurs: outValid becomes 0.
- No accept and no transfer: the bundle holds stable. All out* must stay unchanged while outValid && !outReady.
- Stall: the stage inserts a bubble. It does not accept the instruction, and if the old bundle transfers, outValid becomes 0. Fetch must hold inInstr/inPc.
- Flush has priority over accept and hold. Next edge gives outValid=0 and the instruction is discarded.
- Operand select for operand A (operand B is identical using rt/readData1):
  - if rs==0, the value is 0, regardless of readData0 or the bypass;
  - else if wbWriteEnable && wbWriteAddress==rs, the value is wbWriteData (regFile writes at the same edge, so the read is stale);
  - else the value is readData0.
- outImm = {{16{inInstr[15]}}, inInstr[15:0]}.
- Illegal opcode: outIllegal=1, and outRegWrite/outMemRead/outMemWrite/outBranch/outJump are all 0. The instruction still flows with valid=1.
- Reset asserted mid-transfer: the bundle is dropped and outValid=0 immediately (asynchronous). First accept is possible at the first edge after rst_n rises.

Test Plan:
- Reset then addi $9,$8,5 (0x21090005), inPc=0x40, regFile $8=1 -> one cycle later outValid=1, outRsData=1, outImm=5, outDest=9, outRegWrite=1.
- add $10,$8,$9 with wbWriteEnable=1, wbWriteAddress=9, wbWriteData=0x77, readData1=1 -> outRtData=0x77. Same instruction with wbWriteAddress=0 targeting $0 (rs=0) -> outRsData=0.
- exValid=1, exMemRead=1, exDest=8, incoming add $10,$8,$9 -> inReady=0 for that cycle and outValid=0 next. Drop exValid -> accepted next cycle.
- outReady=0 held 3 cycles with outValid=1 and a new inValid -> inReady=0 and out* unchanged. outReady=1 -> new bundle appears on the following edge.
- flush=1 in the same cycle as inValid=1 -> inReady=0 and outValid=0 next cycle.
- Opcode 111111 -> outIllegal=1 and all control outputs 0. Assert rst_n=0 while outValid=1 -> outValid=0 without waiting for a clock edge.
